axis_video_patgen: RTL and testbench
====================================

AXIS_VIDEO_PATGEN -- requirements
Module: axis_video_patgen

Interface
REQ-001 SHALL: parameter H_ACTIVE, 640, pixels per line; multiple of 8, range 8..4095.
REQ-002 SHALL: parameter V_ACTIVE, 480, lines per frame; range 1..4095.
REQ-003 SHALL: one clock; reset is asynchronous and active-low; ports clk and rstn.
REQ-004 SHALL: clk  input  1  single clock for all logic, rising edge.
REQ-005 SHALL: rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL: enable  input  1  run request, sampled only at frame boundaries.
REQ-007 SHALL: pattern_sel  input  2  pattern select, sampled only at frame boundaries.
REQ-008 SHALL: m_axis_video_tready  input  1  downstream ready.
REQ-009 SHALL: m_axis_video_tdata  output  24  pixel data, RGB888 {R[23:16],G[15:8],B[7:0]}.
REQ-010 SHALL: m_axis_video_tvalid  output  1  beat valid.
REQ-011 SHALL: m_axis_video_tuser  output  1  start of frame, first pixel only.
REQ-012 SHALL: m_axis_video_tlast  output  1  end of line, last pixel of each line.
REQ-013 SHALL: frame_count  output  16  count of completed frames, wraps 0xFFFF->0.
REQ-014 SHALL: busy  output  1  high from frame start through acceptance of the frame's final beat.

Function
REQ-015 SHALL: FSM states IDLE, SEND, GAP; reset state IDLE.
REQ-016 SHALL: IDLE->SEND when enable=1; latch pattern_sel; x=0, y=0; tvalid asserts on the next cycle.
REQ-017 SHALL: transfer only on tvalid&&tready; while tvalid=1 and tready=0, hold tdata/tuser/tlast stable and keep tvalid high.
REQ-018 SHALL: on each transfer, x increments; at x=H_ACTIVE-1, x->0 and y increments; tlast=1 exactly when x=H_ACTIVE-1.
REQ-019 SHALL: tuser=1 exactly when x=0 and y=0.
REQ-020 SHALL: on transfer of pixel (H_ACTIVE-1, V_ACTIVE-1), increment frame_count and deassert busy.
REQ-021 SHALL: at that frame end, go to SEND with a fresh frame if enable=1, with no idle cycle; otherwise go to IDLE.
REQ-022 SHALL: enable deasserted mid-frame finishes the current frame; no truncated frames.
REQ-023 SHALL: pattern 0 is 8 vertical colour bars of width H_ACTIVE/8, driven by a bar counter, not a divider; bar index b selects R=b[2]?FF:00, G=b[1]?FF:00, B=b[0]?FF:00, so bar 0=black and bar 7=white.
REQ-024 SHALL: pattern 1 is ramp {x[7:0], y[7:0], frame_count[7:0]}.
REQ-025 SHALL: pattern 2 is an 8x8 checkerboard: FFFFFF when x[3]^y[3]=1, else 000000.
REQ-026 SHALL: pattern 3 is a linear pixel index within the frame, modulo 2^24, restarting at 0 each frame.
REQ-027 SHALL: produce tdata from registers with zero combinational path from tready to any output except via the state registers.

Reset
REQ-028 SHALL: on rstn=0, all outputs are 0, FSM=IDLE, and x, y, bar counter, throttle counter and frame_count are 0, regardless of state.
REQ-029 SHALL: reset asserted mid-frame abandons the frame; after release, the next frame starts with tuser=1 at pixel (0,0).

Configuration
REQ-030 SHALL: macro AXIS_PATGEN_THROTTLE_EN defined compiles in throttling: after every 4 accepted beats, SEND->GAP for exactly 3 cycles with tvalid=0, then back to SEND.
REQ-031 SHALL: the throttle count continues across line and frame boundaries, reset only by rstn or entry from IDLE.
REQ-032 SHALL: with AXIS_PATGEN_THROTTLE_EN undefined, the GAP state and throttle counter are absent and tvalid stays high throughout SEND.

Structure
REQ-033 SHALL: shared package axis_video_pkg holds the FSM state encoding, the pattern_sel codes (BARS=0, RAMP=1, CHECK=2, INDEX=3) and the RGB888 field positions.
REQ-034 SHALL: one sub-module, axis_patgen_pixel, combinationally maps (pattern, x, y, bar, index, frame_count) to 24-bit RGB; it is registered in the parent.

Verification
REQ-035 SHALL: H_ACTIVE=16, V_ACTIVE=4, tready=1, enable=1, pattern 3 -> 64 beats per frame; tdata 0..63; tlast on beats 15, 31, 47, 63; tuser on beat 0 only; frame_count 0->1.
REQ-036 SHALL: random tready stalls (50%) -> tdata/tuser/tlast unchanged during every stall; beat sequence identical to the no-stall case.
REQ-037 SHALL: pattern 0, H_ACTIVE=16 -> pairs 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF per line.
REQ-038 SHALL: enable dropped at beat 10 of the frame -> all 64 beats delivered, then tvalid=0, busy=0, FSM IDLE.
REQ-039 SHALL: AXIS_PATGEN_THROTTLE_EN, tready=1 -> repeating tvalid pattern 1111000; frame takes 64 + 15*3 = 109 cycles.
REQ-040 SHALL: rstn pulsed low at beat 20 -> outputs 0 immediately; after re-enable, first beat has tuser=1 and tdata=0 (pattern 3).

Source files
------------

// File: rtl/axis_video_pkg.sv
// Shared types for the AXI4-Stream video pattern generator: FSM encoding,
// pattern select codes and the RGB888 pixel layout.
package axis_video_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_INDEX = 2'd3
   } pattern_t;

   // tdata layout: R in [23:16], G in [15:8], B in [7:0]
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/axis_patgen_pixel.sv
// Pure combinational pixel colour lookup; zero latency, no flow control.
// The parent registers the result, so this never sees tready.
module axis_patgen_pixel
   import axis_video_pkg::*;
(
   input  logic [1:0]  pattern_i,
   input  logic [7:0]  x_i,
   input  logic [7:0]  y_i,
   input  logic [2:0]  bar_i,
   input  logic [23:0] index_i,
   input  logic [7:0]  frame_count_i,
   output logic [23:0] rgb_o
);

   rgb_t rgb;

   always_comb begin
      rgb = '0;
      case (pattern_t'(pattern_i))
         PAT_BARS: begin
            rgb.r = {8{bar_i[2]}};
            rgb.g = {8{bar_i[1]}};
            rgb.b = {8{bar_i[0]}};
         end
         PAT_RAMP:  rgb = {x_i, y_i, frame_count_i};
         PAT_CHECK: rgb = (x_i[3] ^ y_i[3]) ? 24'hFF_FFFF : 24'h00_0000;
         default:   rgb = index_i;
      endcase
   end

   assign rgb_o = rgb;

endmodule

// File: rtl/axis_video_patgen.sv
// AXI4-Stream video test-pattern source; first beat one cycle after enable, all outputs registered,
// beats held stable under tready backpressure. Define AXIS_PATGEN_THROTTLE_EN for 4-on/3-off throttling.
module axis_video_patgen
   import axis_video_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic        m_axis_video_tready,
   output logic [23:0] m_axis_video_tdata,
   output logic        m_axis_video_tvalid,
   output logic        m_axis_video_tuser,
   output logic        m_axis_video_tlast,
   output logic [15:0] frame_count,
   output logic        busy
);

   localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
   localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

   state_t      state_q, state_d;
   logic [11:0] x_q, x_d, y_q, y_d, bpx_q, bpx_d;
   logic [2:0]  bar_q, bar_d;
   logic [23:0] idx_q, idx_d;
   logic [1:0]  pat_q, pat_d;
   logic [15:0] fc_q, fc_d;
   logic [23:0] tdata_q, pix;
   logic        tuser_q, tlast_q;
   logic        xfer, frame_end, start;

   assign xfer      = (state_q == ST_SEND) && m_axis_video_tready;
   assign frame_end = xfer && (x_q == X_LAST) && (y_q == Y_LAST);
   assign start     = (state_q == ST_IDLE) && enable;

`ifdef AXIS_PATGEN_THROTTLE_EN
   logic [1:0] thr_q, thr_d, gap_q, gap_d;

   always_comb begin
      thr_d = thr_q;
      if (start)
         thr_d = 2'd0;
      else if (xfer)
         thr_d = thr_q + 2'd1;
      gap_d = (state_q == ST_GAP) ? gap_q + 2'd1 : 2'd0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         thr_q <= 2'd0;
         gap_q <= 2'd0;
      end else begin
         thr_q <= thr_d;
         gap_q <= gap_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (enable) state_d = ST_SEND;
         ST_SEND: begin
            if (frame_end && !enable)
               state_d = ST_IDLE;
`ifdef AXIS_PATGEN_THROTTLE_EN
            else if (xfer && thr_q == 2'd3)
               state_d = ST_GAP;
`endif
         end
`ifdef AXIS_PATGEN_THROTTLE_EN
         ST_GAP:  if (gap_q == 2'd2) state_d = ST_SEND;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      m_axis_video_tvalid = (state_q == ST_SEND);
      busy                = (state_q != ST_IDLE);
   end

   // Counters describe the pixel that the output registers will present next.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      bar_d = bar_q;
      bpx_d = bpx_q;
      idx_d = idx_q;
      pat_d = pat_q;
      fc_d  = fc_q;
      if (start || frame_end) begin
         x_d   = '0;
         y_d   = '0;
         bar_d = '0;
         bpx_d = '0;
         idx_d = '0;
         pat_d = pattern_sel;
         if (frame_end)
            fc_d = fc_q + 16'd1;
      end else if (xfer) begin
         idx_d = idx_q + 24'd1;
         if (x_q == X_LAST) begin
            x_d   = '0;
            y_d   = y_q + 12'd1;
            bar_d = '0;
            bpx_d = '0;
         end else begin
            x_d = x_q + 12'd1;
            if (bpx_q == BAR_LAST) begin
               bpx_d = '0;
               bar_d = bar_q + 3'd1;
            end else begin
               bpx_d = bpx_q + 12'd1;
            end
         end
      end
   end

   axis_patgen_pixel u_pixel (
      .pattern_i     (pat_d),
      .x_i           (x_d[7:0]),
      .y_i           (y_d[7:0]),
      .bar_i         (bar_d),
      .index_i       (idx_d),
      .frame_count_i (fc_d[7:0]),
      .rgb_o         (pix)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x_q     <= '0;
         y_q     <= '0;
         bar_q   <= '0;
         bpx_q   <= '0;
         idx_q   <= '0;
         pat_q   <= '0;
         fc_q    <= '0;
         tdata_q <= '0;
         tuser_q <= 1'b0;
         tlast_q <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         bar_q <= bar_d;
         bpx_q <= bpx_d;
         idx_q <= idx_d;
         pat_q <= pat_d;
         fc_q  <= fc_d;
         if (start || xfer) begin
            tdata_q <= pix;
            tuser_q <= (x_d == 12'd0) && (y_d == 12'd0);
            tlast_q <= (x_d == X_LAST);
         end
      end
   end

   assign m_axis_video_tdata = tdata_q;
   assign m_axis_video_tuser = tuser_q;
   assign m_axis_video_tlast = tlast_q;
   assign frame_count        = fc_q;

endmodule

// File: tb/tb_axis_video_patgen.sv
// Directed bench for axis_video_patgen at 16x4: pattern tables, stalls,
// enable drop, back-to-back frames and mid-frame reset.
module tb_axis_video_patgen;
   import axis_video_pkg::*;

   localparam int H = 16;
   localparam int V = 4;
   localparam int NPIX = H * V;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        tready = 1'b0;
   logic [23:0] tdata;
   logic        tvalid, tuser, tlast, busy;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   axis_video_patgen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .enable              (enable),
      .pattern_sel         (pattern_sel),
      .m_axis_video_tready (tready),
      .m_axis_video_tdata  (tdata),
      .m_axis_video_tvalid (tvalid),
      .m_axis_video_tuser  (tuser),
      .m_axis_video_tlast  (tlast),
      .frame_count         (frame_count),
      .busy                (busy)
   );

   typedef struct {
      logic [1:0]  pat;
      int          beat;
      logic [23:0] data;
      logic        user;
      logic        last;
   } vec_t;

   vec_t        vecs[16];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [23:0] cap_data[0:255];
   logic        cap_user[0:255];
   logic        cap_last[0:255];
   logic [23:0] ref_data[0:63];
   logic        vld_trace[0:255];
   int          cap_cyc;
   int          got;
   int          stall_err;
   int          stall_events;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] model(input logic [1:0] p, input int beat, input int fc);
      logic [31:0] x, y, b, f;
      x = beat % H;
      y = (beat / H) % V;
      b = x / (H / 8);
      f = fc;
      case (p)
         2'd0:    model = {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
         2'd1:    model = {x[7:0], y[7:0], f[7:0]};
         2'd2:    model = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
         default: model = 24'(beat % NPIX);
      endcase
   endfunction

   // Entered and left at the drive point, 1 time unit after a rising edge.
   task automatic capture(input int n, input bit stall, input int drop_at);
      int cyc = 0;
      int first = -1;
      int last = 0;
      bit pend = 1'b0;
      logic [23:0] pd;
      logic pu, pl;
      got = 0;
      stall_err = 0;
      stall_events = 0;
      while (got < n && cyc < 3000) begin
         tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (pend) begin
            if (!tvalid || tdata !== pd || tuser !== pu || tlast !== pl) stall_err++;
            pend = 1'b0;
         end
         if (tvalid && first < 0) first = cyc;
         if (first >= 0 && cyc - first < 256) vld_trace[cyc - first] = tvalid;
         if (tvalid && tready) begin
            cap_data[got] = tdata;
            cap_user[got] = tuser;
            cap_last[got] = tlast;
            got++;
            last = cyc;
            if (got == drop_at) enable = 1'b0;
         end else if (tvalid) begin
            pend = 1'b1;
            stall_events++;
            pd = tdata;
            pu = tuser;
            pl = tlast;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      cap_cyc = (first < 0) ? 0 : last - first + 1;
      check("beats_delivered", got, n);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      enable = 1'b0;
      tready = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input logic [1:0] p, input int fc, input int base);
      for (int i = 0; i < NPIX; i++) begin
         check($sformatf("p%0d_data_%0d", p, i), cap_data[base + i], model(p, i, fc));
         check($sformatf("p%0d_user_%0d", p, i), cap_user[base + i], i == 0);
         check($sformatf("p%0d_last_%0d", p, i), cap_last[base + i], (i % H) == H - 1);
      end
   endtask

   initial begin
      vecs[0]  = '{2'd0, 0,  24'h000000, 1'b1, 1'b0};
      vecs[1]  = '{2'd0, 3,  24'h0000FF, 1'b0, 1'b0};
      vecs[2]  = '{2'd0, 4,  24'h00FF00, 1'b0, 1'b0};
      vecs[3]  = '{2'd0, 7,  24'h00FFFF, 1'b0, 1'b0};
      vecs[4]  = '{2'd0, 9,  24'hFF0000, 1'b0, 1'b0};
      vecs[5]  = '{2'd0, 10, 24'hFF00FF, 1'b0, 1'b0};
      vecs[6]  = '{2'd0, 12, 24'hFFFF00, 1'b0, 1'b0};
      vecs[7]  = '{2'd0, 15, 24'hFFFFFF, 1'b0, 1'b1};
      vecs[8]  = '{2'd1, 17, 24'h010100, 1'b0, 1'b0};
      vecs[9]  = '{2'd1, 63, 24'h0F0300, 1'b0, 1'b1};
      vecs[10] = '{2'd2, 7,  24'h000000, 1'b0, 1'b0};
      vecs[11] = '{2'd2, 8,  24'hFFFFFF, 1'b0, 1'b0};
      vecs[12] = '{2'd2, 40, 24'hFFFFFF, 1'b0, 1'b0};
      vecs[13] = '{2'd3, 0,  24'h000000, 1'b1, 1'b0};
      vecs[14] = '{2'd3, 31, 24'h00001F, 1'b0, 1'b1};
      vecs[15] = '{2'd3, 48, 24'h000030, 1'b0, 1'b0};

      // Reset state
      #1;
      @(posedge clk);
      #1;
      check("rst_tdata", tdata, 0);
      check("rst_tvalid", tvalid, 0);
      check("rst_tuser", tuser, 0);
      check("rst_tlast", tlast, 0);
      check("rst_fc", frame_count, 0);
      check("rst_busy", busy, 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // First beat one cycle after enable, then one frame with enable dropped after beat 0
      pattern_sel = 2'd3;
      enable = 1'b1;
      check("idle_tvalid", tvalid, 0);
      @(posedge clk);
      #1;
      check("start_tvalid", tvalid, 1);
      check("start_busy", busy, 1);
      check("start_tuser", tuser, 1);
      check("start_tdata", tdata, 0);
      capture(NPIX, 1'b0, 1);
      check_frame(2'd3, 0, 0);
`ifdef AXIS_PATGEN_THROTTLE_EN
      check("frame_cycles", cap_cyc, 109);
      begin
         int terr = 0;
         for (int i = 0; i < 109; i++)
            if (vld_trace[i] !== ((i % 7) < 4)) terr++;
         check("throttle_pattern_errs", terr, 0);
      end
`else
      check("frame_cycles", cap_cyc, 64);
`endif
      check("fc_after_frame", frame_count, 1);
      repeat (2) @(posedge clk);
      #1;
      check("end_tvalid", tvalid, 0);
      check("end_busy", busy, 0);

      // Table-driven pattern checks
      for (int p = 0; p < 4; p++) begin
         do_reset();
         pattern_sel = 2'(p);
         enable = 1'b1;
         capture(NPIX, 1'b0, 1);
         check_frame(2'(p), 0, 0);
         for (int k = 0; k < 16; k++) begin
            if (vecs[k].pat == 2'(p)) begin
               check($sformatf("vec%0d_data", k), cap_data[vecs[k].beat], vecs[k].data);
               check($sformatf("vec%0d_user", k), cap_user[vecs[k].beat], vecs[k].user);
               check($sformatf("vec%0d_last", k), cap_last[vecs[k].beat], vecs[k].last);
            end
         end
         if (p == 3)
            for (int i = 0; i < NPIX; i++) ref_data[i] = cap_data[i];
      end

      // Random backpressure: stable while stalled, same beats as without stalls
      do_reset();
      pattern_sel = 2'd3;
      enable = 1'b1;
      capture(NPIX, 1'b1, 1);
      check("stall_hold_errs", stall_err, 0);
      check("stall_seen", stall_events > 0, 1);
      begin
         int derr = 0;
         for (int i = 0; i < NPIX; i++)
            if (cap_data[i] !== ref_data[i]) derr++;
         check("stall_vs_nostall_errs", derr, 0);
      end
      check_frame(2'd3, 0, 0);

      // Enable dropped at beat 10: whole frame still delivered, then idle
      do_reset();
      pattern_sel = 2'd0;
      enable = 1'b1;
      capture(NPIX, 1'b0, 10);
      check_frame(2'd0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("drop_tvalid", tvalid, 0);
      check("drop_busy", busy, 0);
      check("drop_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("drop_fc", frame_count, 1);

      // Back-to-back frames with enable held; ramp picks up the new frame count
      do_reset();
      pattern_sel = 2'd1;
      enable = 1'b1;
      capture(2 * NPIX, 1'b0, -1);
      check_frame(2'd1, 0, 0);
      check_frame(2'd1, 1, NPIX);
      check("b2b_fc", frame_count, 2);
`ifdef AXIS_PATGEN_THROTTLE_EN
      check("b2b_cycles", cap_cyc, 221);
`else
      check("b2b_cycles", cap_cyc, 128);
`endif

      // Reset asserted at beat 20 abandons the frame
      do_reset();
      pattern_sel = 2'd3;
      enable = 1'b1;
      capture(20, 1'b0, -1);
      rstn = 1'b0;
      #1;
      check("mrst_tdata", tdata, 0);
      check("mrst_tvalid", tvalid, 0);
      check("mrst_tuser", tuser, 0);
      check("mrst_tlast", tlast, 0);
      check("mrst_busy", busy, 0);
      check("mrst_fc", frame_count, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      capture(1, 1'b0, -1);
      check("mrst_first_data", cap_data[0], 0);
      check("mrst_first_user", cap_user[0], 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
